// File: rtl/display_pkg.sv
// Shared view indices, seven-segment name codes and sequencer states for the
// register-view display front end.
package display_pkg;

    localparam int NUM_VIEWS = 6;

    localparam logic [2:0] VIEW_AF = 3'd0;
    localparam logic [2:0] VIEW_BC = 3'd1;
    localparam logic [2:0] VIEW_DE = 3'd2;
    localparam logic [2:0] VIEW_HL = 3'd3;
    localparam logic [2:0] VIEW_SP = 3'd4;
    localparam logic [2:0] VIEW_PC = 3'(NUM_VIEWS - 1);

    localparam logic [3:0] CODE_A = 4'h0;
    localparam logic [3:0] CODE_F = 4'h1;
    localparam logic [3:0] CODE_B = 4'h2;
    localparam logic [3:0] CODE_C = 4'h3;
    localparam logic [3:0] CODE_D = 4'h4;
    localparam logic [3:0] CODE_E = 4'h5;
    localparam logic [3:0] CODE_H = 4'h6;
    localparam logic [3:0] CODE_L = 4'h7;
    localparam logic [3:0] CODE_P = 4'h8;
    localparam logic [3:0] CODE_S = 4'hB;

    typedef enum logic [1:0] {SEL, CAPTURE, SHOW} state_e;

    // Returns {left digit code, right digit code} for a view.
    function automatic logic [7:0] name_codes(input logic [2:0] view);
        case (view)
            VIEW_AF: name_codes = {CODE_A, CODE_F};
            VIEW_BC: name_codes = {CODE_B, CODE_C};
            VIEW_DE: name_codes = {CODE_D, CODE_E};
            VIEW_HL: name_codes = {CODE_H, CODE_L};
            VIEW_SP: name_codes = {CODE_S, CODE_P};
            VIEW_PC: name_codes = {CODE_P, CODE_C};
            default: name_codes = {CODE_A, CODE_F};
        endcase
    endfunction

    function automatic logic [2:0] view_step(input logic [2:0] view, input logic up);
        if (up) view_step = (view == VIEW_PC) ? VIEW_AF : view + 3'd1;
        else    view_step = (view == VIEW_AF) ? VIEW_PC : view - 3'd1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Active-low pushbutton conditioner: two-flop synchronizer, stability counter
// and a one-cycle press pulse on the accepted released->pressed transition.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw_i,
    output logic press_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q <= key_raw_i;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            // Any return to the stable level restarts the qualification window.
            if (sync2_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_q <= sync2_q;
                cnt_q    <= '0;
                press_q  <= ~sync2_q;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/reg_view_sequencer.sv
// Selects which CPU register pair is shown, steps views on keys or a timer,
// and snapshots the pair value returned by the external register-file mux.
module reg_view_sequencer
    import display_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int AUTO_PERIOD     = 50000000,
    parameter int REFRESH_PERIOD  = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        keyNext,
    input  logic        keyPrev,
    input  logic        autoEn,
    input  logic        freeze,
    input  logic [15:0] regData,
    output logic [2:0]  regSel,
    output logic [3:0]  nameCodeHi,
    output logic [3:0]  nameCodeLo,
    output logic        dotHi,
    output logic        dotLo,
    output logic [15:0] valueOut,
    output logic        capValid
);

    localparam int AW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam int RW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_PERIOD - 1);
    localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_PERIOD - 1);

    logic          next_ev;
    logic          prev_ev;
    logic          tick;
    logic          step_d;
    logic          step_up_d;
    logic          apply_d;
    logic          apply_up_d;
    logic [2:0]    view_d;

    state_e        state_q;
    logic [AW-1:0] auto_q;
    logic [RW-1:0] ref_q;
    logic [2:0]    view_q;
    logic [3:0]    name_hi_q;
    logic [3:0]    name_lo_q;
    logic [15:0]   value_q;
    logic          cap_q;
    logic          dot_hi_q;
    logic          dot_lo_q;
    logic          pend_q;
    logic          pend_up_q;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_next (
        .clk       (clk),
        .rst       (rst),
        .key_raw_i (keyNext),
        .press_o   (next_ev)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_prev (
        .clk       (clk),
        .rst       (rst),
        .key_raw_i (keyPrev),
        .press_o   (prev_ev)
    );

    // Manual presses win over a coincident tick; opposing presses cancel.
    always_comb begin
        tick      = autoEn && (auto_q == AUTO_LAST);
        step_d    = 1'b0;
        step_up_d = 1'b1;
        if (next_ev && prev_ev) begin
            step_d = 1'b0;
        end else if (next_ev) begin
            step_d = 1'b1;
        end else if (prev_ev) begin
            step_d    = 1'b1;
            step_up_d = 1'b0;
        end else if (tick) begin
            step_d = 1'b1;
        end
        apply_d    = step_d | pend_q;
        apply_up_d = step_d ? step_up_d : pend_up_q;
        view_d     = view_step(view_q, apply_up_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            auto_q <= '0;
        end else if (!autoEn || next_ev || prev_ev || tick) begin
            auto_q <= '0;
        end else begin
            auto_q <= auto_q + AW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SEL;
            ref_q     <= '0;
            view_q    <= VIEW_AF;
            name_hi_q <= CODE_A;
            name_lo_q <= CODE_F;
            value_q   <= '0;
            cap_q     <= 1'b0;
            dot_hi_q  <= 1'b1;
            dot_lo_q  <= 1'b1;
            pend_q    <= 1'b0;
            pend_up_q <= 1'b1;
        end else begin
            dot_hi_q <= ~autoEn;
            dot_lo_q <= ~freeze;
            cap_q    <= 1'b0;
            case (state_q)
                SEL: begin
                    if (step_d) begin
                        pend_q    <= 1'b1;
                        pend_up_q <= step_up_d;
                    end
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    if (step_d) begin
                        pend_q    <= 1'b1;
                        pend_up_q <= step_up_d;
                    end
                    value_q <= regData;
                    cap_q   <= 1'b1;
                    ref_q   <= '0;
                    state_q <= SHOW;
                end
                SHOW: begin
                    if (apply_d) begin
                        view_q                 <= view_d;
                        {name_hi_q, name_lo_q} <= name_codes(view_d);
                        pend_q                 <= 1'b0;
                        state_q                <= SEL;
                    end else if (ref_q != REF_LAST) begin
                        ref_q <= ref_q + RW'(1);
                    end else if (!freeze) begin
                        state_q <= SEL;
                    end
                end
                default: state_q <= SEL;
            endcase
        end
    end

    assign regSel     = view_q;
    assign nameCodeHi = name_hi_q;
    assign nameCodeLo = name_lo_q;
    assign dotHi      = dot_hi_q;
    assign dotLo      = dot_lo_q;
    assign valueOut   = value_q;
    assign capValid   = cap_q;

endmodule

// File: tb/tb_reg_view_sequencer.sv
// Bench for reg_view_sequencer with short debounce, auto and refresh periods;
// view changes are scored against an expected queue of {regSel, names}.
module tb_reg_view_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        keyNext = 1'b1;
    logic        keyPrev = 1'b1;
    logic        autoEn = 1'b0;
    logic        freeze = 1'b0;
    logic [15:0] regData;
    logic [2:0]  regSel;
    logic [3:0]  nameCodeHi;
    logic [3:0]  nameCodeLo;
    logic        dotHi;
    logic        dotLo;
    logic [15:0] valueOut;
    logic        capValid;

    logic [15:0] reg_mem [0:7];
    logic [10:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [2:0]  last_sel = 3'd0;

    reg_view_sequencer #(
        .DEBOUNCE_CYCLES (4),
        .AUTO_PERIOD     (20),
        .REFRESH_PERIOD  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .keyNext    (keyNext),
        .keyPrev    (keyPrev),
        .autoEn     (autoEn),
        .freeze     (freeze),
        .regData    (regData),
        .regSel     (regSel),
        .nameCodeHi (nameCodeHi),
        .nameCodeLo (nameCodeLo),
        .dotHi      (dotHi),
        .dotLo      (dotLo),
        .valueOut   (valueOut),
        .capValid   (capValid)
    );

    // Register-file mux model.
    assign regData = reg_mem[regSel];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] exp_view(input int v);
        logic [7:0] nm;
        case (v)
            0: nm = 8'h01;
            1: nm = 8'h23;
            2: nm = 8'h45;
            3: nm = 8'h67;
            4: nm = 8'hB8;
            5: nm = 8'h83;
            default: nm = 8'hxx;
        endcase
        return {3'(v), nm};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            last_sel = 3'd0;
        end else if (regSel !== last_sel) begin
            if (exp_q.size() == 0)
                check("view_unexpected", 32'(regSel), 32'(last_sel));
            else
                check("view", 32'({regSel, nameCodeHi, nameCodeLo}), 32'(exp_q.pop_front()));
            last_sel = regSel;
        end
    end

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit nxt, input int hold);
        if (nxt) keyNext = 1'b0;
        else     keyPrev = 1'b0;
        tick_n(hold);
        keyNext = 1'b1;
        keyPrev = 1'b1;
        tick_n(8);
    endtask

    task automatic drain(input string tag);
        int w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    task automatic wait_change(output int at);
        logic [2:0] old;
        old = regSel;
        at  = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (regSel !== old) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check("change_timeout", 32'(regSel), 32'(old) + 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_regSel"}, 32'(regSel), 0);
        check({tag, "_names"}, 32'({nameCodeHi, nameCodeLo}), 'h01);
        check({tag, "_dotHi"}, 32'(dotHi), 1);
        check({tag, "_dotLo"}, 32'(dotLo), 1);
        check({tag, "_valueOut"}, 32'(valueOut), 0);
        check({tag, "_capValid"}, 32'(capValid), 0);
    endtask

    initial begin
        int c1, c2, c3, c4;
        int caps;
        for (int i = 0; i < 8; i++) reg_mem[i] = 16'hA000 + 16'(i);
        reg_mem[0] = 16'h01B0;
        reg_mem[1] = 16'h0013;

        // Reset values and first capture.
        tick_n(3);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);
        check("first_cap_early", 32'(capValid), 0);
        @(negedge clk);
        check("first_cap", 32'(capValid), 1);
        check("first_value", 32'(valueOut), 'h01B0);

        // Glitchy keyNext followed by a solid press.
        repeat (2) begin
            keyNext = 1'b0;
            tick_n(2);
            keyNext = 1'b1;
            tick_n(2);
        end
        exp_q.push_back(exp_view(1));
        keyNext = 1'b0;
        wait_change(c1);
        @(negedge clk);
        check("lat_cap_early", 32'(capValid), 0);
        @(negedge clk);
        check("lat_cap", 32'(capValid), 1);
        check("lat_value", 32'(valueOut), 'h0013);
        tick_n(6);
        keyNext = 1'b1;
        tick_n(8);
        drain("drain_glitch");

        // Backward wrap, then forward wrap.
        exp_q.push_back(exp_view(0));
        press(1'b0, 10);
        exp_q.push_back(exp_view(5));
        press(1'b0, 10);
        exp_q.push_back(exp_view(4));
        press(1'b0, 10);
        exp_q.push_back(exp_view(3));
        press(1'b0, 10);
        drain("drain_prev");
        for (int v = 4; v < 8; v++) begin
            exp_q.push_back(exp_view(v % 6));
            press(1'b1, 10);
        end
        drain("drain_next");

        // Auto-step, and a press landing on the tick cycle.
        freeze = 1'b1;
        tick_n(15);
        autoEn = 1'b1;
        exp_q.push_back(exp_view(2));
        exp_q.push_back(exp_view(3));
        tick_n(2);
        check("auto_dotHi", 32'(dotHi), 0);
        wait_change(c1);
        wait_change(c2);
        check("auto_period", c2 - c1, 20);
        tick_n(13);
        keyNext = 1'b0;
        exp_q.push_back(exp_view(4));
        wait_change(c3);
        check("collide_period", c3 - c2, 20);
        check("collide_view", 32'(regSel), 4);
        tick_n(5);
        keyNext = 1'b1;
        exp_q.push_back(exp_view(5));
        wait_change(c4);
        check("after_collide_period", c4 - c3, 20);
        autoEn = 1'b0;
        tick_n(10);
        drain("drain_auto");
        check("auto_off_dotHi", 32'(dotHi), 1);

        // Freeze suppresses refresh.
        freeze = 1'b0;
        reg_mem[5] = 16'h1234;
        tick_n(15);
        check("refresh_value", 32'(valueOut), 'h1234);
        freeze = 1'b1;
        tick_n(3);
        check("freeze_dotLo", 32'(dotLo), 0);
        reg_mem[5] = 16'h5678;
        caps = 0;
        repeat (50) begin
            @(negedge clk);
            if (capValid) caps++;
        end
        check("freeze_caps", caps, 0);
        check("freeze_value", 32'(valueOut), 'h1234);
        freeze = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (capValid) break;
        end
        check("unfreeze_cap", 32'(capValid), 1);
        check("unfreeze_value", 32'(valueOut), 'h5678);

        // Reset during CAPTURE with a pending backward step.
        freeze = 1'b1;
        tick_n(15);
        exp_q.push_back(exp_view(0));
        keyNext = 1'b0;
        @(negedge clk);
        keyPrev = 1'b0;
        wait_change(c1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_values("midreset");
        keyNext = 1'b1;
        keyPrev = 1'b1;
        freeze  = 1'b0;
        tick_n(3);
        rst = 1'b0;
        tick_n(40);
        check("no_pending_view", 32'(regSel), 0);
        check("post_reset_value", 32'(valueOut), 32'(reg_mem[0]));
        check("post_reset_queue", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
